// File: rtl/psc_trigger_pkg.sv
// psc_trigger_pkg
// Shared definitions for the PSC trigger link. The transmitter ROM and this
// receiver both use them.
//   SYNC_BYTE     : first byte of every frame.
//   CRC8_POLY     : CRC-8 polynomial x^8+x^2+x+1. Init 0x00, no reflection,
//                   no final XOR.
//   bit_state_t   : states of the serial bit recovery FSM.
//   frame_state_t : states of the frame assembly FSM.
//   crc8_update() : folds one byte into a running CRC-8, MSB first.
package psc_trigger_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h7E;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [2:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP,
    BIT_WAIT_HIGH
  } bit_state_t;

  typedef enum logic [1:0] {
    FR_HUNT,
    FR_GET_CMD,
    FR_GET_ARG,
    FR_GET_CRC
  } frame_state_t;

  function automatic logic [7:0] crc8_update(input logic [7:0] crc,
                                             input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/psc_trigger_rx_bit.sv
// psc_trigger_rx_bit
// Synchronizes the asynchronous serial line and recovers 10-bit words.
// Each word is a start bit (0), 8 data bits sent MSB first, and a stop bit (1).
// Bit values are taken near the middle of each bit period by counting clk
// cycles from the falling edge of the start bit.
//   clk           : system clock
//   reset         : synchronous, active-low
//   rx_serial     : raw serial input; idles high
//   data_byte     : last received byte. Valid while byte_strobe is high.
//   byte_strobe   : one-cycle pulse when a word ends with a good stop bit
//   framing_error : one-cycle pulse when the stop bit is sampled low
//   line_idle     : high while the bit FSM waits for a start bit
// OVERSAMPLE is the number of clk cycles per bit and must be >= 3.
module psc_trigger_rx_bit
  import psc_trigger_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] data_byte,
  output logic       byte_strobe,
  output logic       framing_error,
  output logic       line_idle
);

  localparam int unsigned HALF  = OVERSAMPLE / 2;
  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);

  logic [1:0]       sync_reg;
  logic             rx_prev_reg;
  logic [1:0]       prime_reg;
  logic             seen_high_reg;
  bit_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             byte_strobe_reg;
  logic             framing_error_reg;

  logic rx_s;
  logic fall_edge;

  assign rx_s = sync_reg[1];

  // The synchronizer flops load 1 during reset. A line that is already low
  // when reset is released would therefore look like a falling edge. To
  // prevent this, edges are accepted only after a real synchronized sample
  // has read high. prime_reg[1] marks that sync_reg[1] now holds a real
  // sample and not a reset value.
  assign fall_edge = seen_high_reg & rx_prev_reg & ~rx_s;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_reg      <= 2'b11;
      rx_prev_reg   <= 1'b1;
      prime_reg     <= 2'b00;
      seen_high_reg <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[0], rx_serial};
      rx_prev_reg   <= rx_s;
      prime_reg     <= {prime_reg[0], 1'b1};
      seen_high_reg <= seen_high_reg | (prime_reg[1] & rx_s);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg         <= BIT_IDLE;
      cnt_reg           <= '0;
      bit_idx_reg       <= 3'd0;
      shift_reg         <= 8'h00;
      byte_strobe_reg   <= 1'b0;
      framing_error_reg <= 1'b0;
    end else begin
      byte_strobe_reg   <= 1'b0;
      framing_error_reg <= 1'b0;
      case (state_reg)
        BIT_IDLE: begin
          if (fall_edge) begin
            state_reg <= BIT_START;
            cnt_reg   <= '0;
          end
        end
        BIT_START: begin
          // Half a bit period after the edge is the middle of the start bit.
          if (cnt_reg == CNT_W'(HALF - 1)) begin
            cnt_reg <= '0;
            if (rx_s) begin
              state_reg <= BIT_IDLE;
            end else begin
              state_reg   <= BIT_DATA;
              bit_idx_reg <= 3'd0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        BIT_DATA: begin
          if (cnt_reg == CNT_W'(OVERSAMPLE - 1)) begin
            cnt_reg   <= '0;
            shift_reg <= {shift_reg[6:0], rx_s};
            if (bit_idx_reg == 3'd7) begin
              state_reg <= BIT_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        BIT_STOP: begin
          if (cnt_reg == CNT_W'(OVERSAMPLE - 1)) begin
            cnt_reg <= '0;
            if (rx_s) begin
              byte_strobe_reg <= 1'b1;
              state_reg       <= BIT_IDLE;
            end else begin
              framing_error_reg <= 1'b1;
              state_reg         <= BIT_WAIT_HIGH;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        BIT_WAIT_HIGH: begin
          // The line must return high before a new start bit can be trusted.
          if (rx_s) begin
            state_reg <= BIT_IDLE;
          end
        end
        default: state_reg <= BIT_IDLE;
      endcase
    end
  end

  assign data_byte     = shift_reg;
  assign byte_strobe   = byte_strobe_reg;
  assign framing_error = framing_error_reg;
  assign line_idle     = (state_reg == BIT_IDLE);

endmodule

// File: rtl/psc_trigger_receiver.sv
// psc_trigger_receiver
// Receiver for the PSC trigger link on the power-supply-controller side.
// Recovers bytes from the serial line and assembles SYNC/CMD/ARG/CRC frames.
// It checks the CRC-8 over CMD and ARG, then reports the result as
// one-cycle pulses.
//   clk           : system clock (50 MHz)
//   reset         : synchronous, active-low
//   rx_serial     : serial line from the transmitter; asynchronous, idles high
//   cmd, arg      : command/argument of the last good frame
//   frame_valid   : one-cycle pulse for a good frame
//   trigger_out   : one-cycle pulse for a good frame with cmd == TRIG_CMD
//   crc_error     : one-cycle pulse for a CRC mismatch
//   framing_error : one-cycle pulse when a stop bit is sampled low
// Optional build macro PSC_TRIGGER_RX_STATS_EN adds two counters:
//   good_count, err_count : saturating 16-bit counters of good frames and of
//                           crc/framing errors
module psc_trigger_receiver
  import psc_trigger_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = 5,
  parameter logic [7:0]  TRIG_CMD    = 8'h01,
  parameter int unsigned GAP_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] cmd,
  output logic [7:0] arg,
  output logic       frame_valid,
  output logic       trigger_out,
  output logic       crc_error,
  output logic       framing_error
`ifdef PSC_TRIGGER_RX_STATS_EN
  , output logic [15:0] good_count
  , output logic [15:0] err_count
`endif
);

  localparam int unsigned GAP_W = $clog2(GAP_TIMEOUT + 1);

  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       rx_ferr;
  logic       line_idle;

  psc_trigger_rx_bit #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_rx_bit (
    .clk          (clk),
    .reset        (reset),
    .rx_serial    (rx_serial),
    .data_byte    (rx_byte),
    .byte_strobe  (rx_strobe),
    .framing_error(rx_ferr),
    .line_idle    (line_idle)
  );

  frame_state_t     state_reg;
  logic [7:0]       crc_reg;
  logic [7:0]       cmd_shadow_reg;
  logic [7:0]       arg_shadow_reg;
  logic [7:0]       cmd_reg;
  logic [7:0]       arg_reg;
  logic             frame_valid_reg;
  logic             trigger_reg;
  logic             crc_error_reg;
  logic             framing_error_reg;
  logic [GAP_W-1:0] gap_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg         <= FR_HUNT;
      crc_reg           <= 8'h00;
      cmd_shadow_reg    <= 8'h00;
      arg_shadow_reg    <= 8'h00;
      cmd_reg           <= 8'h00;
      arg_reg           <= 8'h00;
      frame_valid_reg   <= 1'b0;
      trigger_reg       <= 1'b0;
      crc_error_reg     <= 1'b0;
      framing_error_reg <= 1'b0;
      gap_reg           <= '0;
    end else begin
      frame_valid_reg   <= 1'b0;
      trigger_reg       <= 1'b0;
      crc_error_reg     <= 1'b0;
      framing_error_reg <= 1'b0;

      // Count idle cycles between the words of a frame. A start bit moves the
      // bit FSM out of idle, which clears the count.
      if (state_reg == FR_HUNT || !line_idle) begin
        gap_reg <= '0;
      end else begin
        gap_reg <= gap_reg + 1'b1;
      end

      if (rx_ferr) begin
        framing_error_reg <= 1'b1;
        state_reg         <= FR_HUNT;
      end else if (rx_strobe) begin
        case (state_reg)
          FR_HUNT: begin
            if (rx_byte == SYNC_BYTE) begin
              crc_reg   <= 8'h00;
              state_reg <= FR_GET_CMD;
            end
          end
          // Inside a frame, 0x7E is ordinary payload and does not resync.
          FR_GET_CMD: begin
            cmd_shadow_reg <= rx_byte;
            crc_reg        <= crc8_update(crc_reg, rx_byte);
            state_reg      <= FR_GET_ARG;
          end
          FR_GET_ARG: begin
            arg_shadow_reg <= rx_byte;
            crc_reg        <= crc8_update(crc_reg, rx_byte);
            state_reg      <= FR_GET_CRC;
          end
          FR_GET_CRC: begin
            if (rx_byte == crc_reg) begin
              cmd_reg         <= cmd_shadow_reg;
              arg_reg         <= arg_shadow_reg;
              frame_valid_reg <= 1'b1;
              trigger_reg     <= (cmd_shadow_reg == TRIG_CMD);
            end else begin
              crc_error_reg <= 1'b1;
            end
            state_reg <= FR_HUNT;
          end
          default: state_reg <= FR_HUNT;
        endcase
      end else if (state_reg != FR_HUNT && line_idle &&
                   gap_reg == GAP_W'(GAP_TIMEOUT - 1)) begin
        // The transmitter stopped mid-frame. Drop the frame without reporting.
        state_reg <= FR_HUNT;
      end
    end
  end

  assign cmd           = cmd_reg;
  assign arg           = arg_reg;
  assign frame_valid   = frame_valid_reg;
  assign trigger_out   = trigger_reg;
  assign crc_error     = crc_error_reg;
  assign framing_error = framing_error_reg;

`ifdef PSC_TRIGGER_RX_STATS_EN
  logic [15:0] good_count_reg;
  logic [15:0] err_count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      good_count_reg <= 16'h0000;
      err_count_reg  <= 16'h0000;
    end else begin
      if (frame_valid_reg && good_count_reg != 16'hFFFF) begin
        good_count_reg <= good_count_reg + 16'd1;
      end
      if ((crc_error_reg || framing_error_reg) && err_count_reg != 16'hFFFF) begin
        err_count_reg <= err_count_reg + 16'd1;
      end
    end
  end

  assign good_count = good_count_reg;
  assign err_count  = err_count_reg;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_psc_trigger_receiver.sv
module tb_psc_trigger_receiver;

  localparam int         OS   = 5;
  localparam logic [7:0] TRIG = 8'h01;
  localparam int         GAP  = 64;
  // Cycles from the edge that first samples the low start bit to the edge
  // that makes the result pulse visible. That is two synchronizer flops,
  // half a bit to the start-bit centre, nine bit periods to the stop-bit
  // centre, and one cycle for the output register.
  localparam int         LAT  = 2 + OS / 2 + 9 * OS + 1;
  localparam int         MAXC = 8192;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] cmd;
  logic [7:0] arg;
  logic       frame_valid;
  logic       trigger_out;
  logic       crc_error;
  logic       framing_error;
`ifdef PSC_TRIGGER_RX_STATS_EN
  logic [15:0] good_count;
  logic [15:0] err_count;
`endif

  psc_trigger_receiver #(
    .OVERSAMPLE (OS),
    .TRIG_CMD   (TRIG),
    .GAP_TIMEOUT(GAP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_serial    (rx_serial),
    .cmd          (cmd),
    .arg          (arg),
    .frame_valid  (frame_valid),
    .trigger_out  (trigger_out),
    .crc_error    (crc_error),
    .framing_error(framing_error)
`ifdef PSC_TRIGGER_RX_STATS_EN
    , .good_count (good_count)
    , .err_count  (err_count)
`endif
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  // Expected results, indexed by cycle.
  bit         ev_fv   [MAXC];
  bit         ev_trig [MAXC];
  bit         ev_crc  [MAXC];
  bit         ev_ferr [MAXC];
  bit         ev_ld   [MAXC];
  bit         ev_rst  [MAXC];
  logic [7:0] ev_cmd  [MAXC];
  logic [7:0] ev_arg  [MAXC];

  // Frame-level model state. 0=hunt, 1=want cmd, 2=want arg, 3=want crc.
  int         m_state = 0;
  logic [7:0] m_c = 8'h00;
  logic [7:0] m_a = 8'h00;
  int         last_k = -100000;

  int fv_seen = 0, trig_seen = 0, crc_seen = 0, ferr_seen = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // CRC-8 computed as the remainder of {cmd,arg}*x^8 divided by 0x107.
  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] a);
    logic [23:0] r;
    r = {c, a, 8'h00};
    for (int i = 23; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    end
    return r[7:0];
  endfunction

  // Word whose low start bit is first sampled at edge k.
  task automatic model_word(input int k, input logic [7:0] b, input bit stop_ok);
    int t;
    t = k + LAT;
    if (m_state != 0 && (k - (last_k + 10 * OS)) >= GAP) m_state = 0;
    last_k = k;
    if (t >= MAXC) return;
    if (!stop_ok) begin
      ev_ferr[t] = 1'b1;
      m_state = 0;
    end else begin
      case (m_state)
        0: if (b == 8'h7E) m_state = 1;
        1: begin m_c = b; m_state = 2; end
        2: begin m_a = b; m_state = 3; end
        default: begin
          if (b == ref_crc(m_c, m_a)) begin
            ev_fv[t]   = 1'b1;
            ev_trig[t] = (m_c == TRIG);
            ev_ld[t]   = 1'b1;
            ev_cmd[t]  = m_c;
            ev_arg[t]  = m_a;
          end else begin
            ev_crc[t] = 1'b1;
          end
          m_state = 0;
        end
      endcase
    end
  endtask

  // Callers are aligned 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] b, input bit stop_ok);
    model_word(cyc + 1, b, stop_ok);
    rx_serial = 1'b0;
    idle(OS);
    for (int i = 7; i >= 0; i--) begin
      rx_serial = b[i];
      idle(OS);
    end
    rx_serial = stop_ok;
    idle(OS);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] crc);
    send_word(8'h7E, 1'b1);
    send_word(c, 1'b1);
    send_word(a, 1'b1);
    send_word(crc, 1'b1);
    idle(20);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b0;
    rx_serial = 1'b1;
    ev_rst[cyc + 1] = 1'b1;
    ev_ld[cyc + 1]  = 1'b1;
    ev_cmd[cyc + 1] = 8'h00;
    ev_arg[cyc + 1] = 8'h00;
    m_state = 0;
    idle(n);
    reset = 1'b1;
  endtask

  // Every cycle, compare all DUT outputs against the model.
  initial begin
    logic [7:0]  m_cmd;
    logic [7:0]  m_arg;
    logic [15:0] m_good;
    logic [15:0] m_err;
    m_cmd = 8'h00; m_arg = 8'h00; m_good = 16'h0; m_err = 16'h0;
    forever begin
      @(negedge clk);
      if (cyc >= 1 && cyc < MAXC) begin
        if (ev_ld[cyc]) begin
          m_cmd = ev_cmd[cyc];
          m_arg = ev_arg[cyc];
        end
        if (ev_rst[cyc]) begin
          m_good = 16'h0;
          m_err  = 16'h0;
        end else begin
          if (ev_fv[cyc-1] && m_good != 16'hFFFF) m_good = m_good + 16'd1;
          if ((ev_crc[cyc-1] || ev_ferr[cyc-1]) && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        end
        chk("frame_valid",   16'(frame_valid),   16'(ev_fv[cyc]));
        chk("trigger_out",   16'(trigger_out),   16'(ev_trig[cyc]));
        chk("crc_error",     16'(crc_error),     16'(ev_crc[cyc]));
        chk("framing_error", 16'(framing_error), 16'(ev_ferr[cyc]));
        chk("cmd",           16'(cmd),           16'(m_cmd));
        chk("arg",           16'(arg),           16'(m_arg));
`ifdef PSC_TRIGGER_RX_STATS_EN
        chk("good_count", good_count, m_good);
        chk("err_count",  err_count,  m_err);
`endif
        if (frame_valid === 1'b1)   fv_seen++;
        if (trigger_out === 1'b1)   trig_seen++;
        if (crc_error === 1'b1)     crc_seen++;
        if (framing_error === 1'b1) ferr_seen++;
      end
    end
  end

  initial begin
    apply_reset(3);
    idle(10);
    $display("reset released: cmd=%0h arg=%0h", cmd, arg);

    send_frame(8'h01, 8'h00, 8'h15);
    $display("frame 7E 01 00 15: trig=%0d fv=%0d cmd=%0h arg=%0h", trig_seen, fv_seen, cmd, arg);
    chk("lit_f1_trig", 16'(trig_seen), 16'd1);
    chk("lit_f1_fv",   16'(fv_seen),   16'd1);
    chk("lit_f1_cmd",  16'(cmd),       16'h01);
    chk("lit_f1_arg",  16'(arg),       16'h00);

    send_frame(8'h02, 8'h00, 8'h2A);
    $display("frame 7E 02 00 2A: trig=%0d fv=%0d cmd=%0h", trig_seen, fv_seen, cmd);
    chk("lit_f2_fv",   16'(fv_seen),   16'd2);
    chk("lit_f2_trig", 16'(trig_seen), 16'd1);
    chk("lit_f2_cmd",  16'(cmd),       16'h02);

    send_frame(8'h01, 8'h00, 8'h16);
    $display("frame 7E 01 00 16: crc_err=%0d fv=%0d cmd=%0h", crc_seen, fv_seen, cmd);
    chk("lit_f3_crc", 16'(crc_seen), 16'd1);
    chk("lit_f3_fv",  16'(fv_seen),  16'd2);
    chk("lit_f3_cmd", 16'(cmd),      16'h02);

    send_frame(8'h01, 8'h00, 8'h15);
    $display("frame 7E 01 00 15 after crc error: trig=%0d", trig_seen);
    chk("lit_f4_trig", 16'(trig_seen), 16'd2);

    send_word(8'h7E, 1'b1);
    send_word(8'h01, 1'b1);
    send_word(8'h00, 1'b0);
    rx_serial = 1'b1;
    idle(20);
    $display("low stop bit in ARG: framing_err=%0d fv=%0d", ferr_seen, fv_seen);
    chk("lit_ferr", 16'(ferr_seen), 16'd1);
    chk("lit_ferr_fv", 16'(fv_seen), 16'd3);

    send_frame(8'h03, 8'h7E, ref_crc(8'h03, 8'h7E));
    $display("frame 7E 03 7E crc: fv=%0d cmd=%0h arg=%0h", fv_seen, cmd, arg);
    chk("lit_f5_arg", 16'(arg), 16'h7E);
    send_frame(8'h7E, 8'h01, ref_crc(8'h7E, 8'h01));
    $display("frame 7E 7E 01 crc: fv=%0d cmd=%0h arg=%0h", fv_seen, cmd, arg);
    chk("lit_f6_cmd", 16'(cmd), 16'h7E);
    chk("lit_f6_fv",  16'(fv_seen), 16'd5);

    rx_serial = 1'b0;
    idle(1);
    rx_serial = 1'b1;
    idle(20);
    $display("1-cycle glitch: fv=%0d ferr=%0d", fv_seen, ferr_seen);
    chk("lit_glitch_fv",   16'(fv_seen),   16'd5);
    chk("lit_glitch_ferr", 16'(ferr_seen), 16'd1);

    send_word(8'h7E, 1'b1);
    send_word(8'h01, 1'b1);
    idle(100);
    send_word(8'h00, 1'b1);
    send_word(8'h15, 1'b1);
    idle(20);
    $display("gap timeout frame: trig=%0d fv=%0d", trig_seen, fv_seen);
    chk("lit_timeout_trig", 16'(trig_seen), 16'd2);

`ifdef PSC_TRIGGER_RX_STATS_EN
    $display("stats: good=%0d err=%0d", good_count, err_count);
    chk("lit_good_count", good_count, 16'd5);
    chk("lit_err_count",  err_count,  16'd2);
`endif

    // Reset during the ARG word, then send a clean frame.
    send_word(8'h7E, 1'b1);
    send_word(8'h01, 1'b1);
    rx_serial = 1'b0;
    idle(OS);
    rx_serial = 1'b0;
    idle(3 * OS);
    apply_reset(3);
    idle(10);
    $display("reset mid-ARG: cmd=%0h arg=%0h", cmd, arg);
    chk("lit_rst_cmd", 16'(cmd), 16'h00);
    send_frame(8'h01, 8'h00, 8'h15);
    $display("frame after reset: trig=%0d cmd=%0h", trig_seen, cmd);
    chk("lit_rst_trig", 16'(trig_seen), 16'd3);
    chk("lit_rst_cmd2", 16'(cmd), 16'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
